// File: rtl/mem_stage_if.sv
// Data-memory request/response channel between the MEM stage (master) and memory (slave).
interface mem_stage_if #(
    parameter int DATA_W = 16
);
    logic              dmem_req;
    logic              dmem_we;
    logic [DATA_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic [DATA_W-1:0] dmem_rdata;
    logic              dmem_ready;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_rdata, dmem_ready
    );
    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_rdata, dmem_ready
    );
endinterface

// File: rtl/mem_stage.sv
// microRISC memory-access stage: EX/MEM and MEM/WB registers, data-memory handshake,
// upstream stall generation and the two forwarding sources for the execute stage.
module mem_stage #(
    parameter int DATA_W  = 16,
    parameter int RADDR_W = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ex_valid,
    input  logic [DATA_W-1:0]  ex_alu_result,
    input  logic [DATA_W-1:0]  ex_store_data,
    input  logic [RADDR_W-1:0] ex_write_reg_addr,
    input  logic               ex_reg_write,
    input  logic               ex_mem_read,
    input  logic               ex_mem_write,
    input  logic               ex_mem_to_reg,
    output logic               mem_stall,
    mem_stage_if.master        dmem,
    output logic [DATA_W-1:0]  mem_forward_data,
    output logic [RADDR_W-1:0] mem_write_reg_addr,
    output logic               mem_reg_write,
    output logic               wb_valid,
    output logic               wb_reg_write,
    output logic [RADDR_W-1:0] wb_write_reg_addr,
    output logic [DATA_W-1:0]  wb_write_data,
    output logic [DATA_W-1:0]  wb_forward_data,
    output logic [15:0]        stall_count
);
    typedef struct packed {
        logic               valid;
        logic [DATA_W-1:0]  alu_result;
        logic [DATA_W-1:0]  store_data;
        logic [RADDR_W-1:0] write_reg_addr;
        logic               reg_write;
        logic               mem_read;
        logic               mem_write;
        logic               mem_to_reg;
    } exmem_t;

    typedef enum logic {IDLE, BUSY} state_t;

    exmem_t            ex_in, m;
    state_t            state, state_nxt;
    logic              m_op;
    logic [DATA_W-1:0] wb_data_nxt;

    assign ex_in = '{valid: ex_valid, alu_result: ex_alu_result, store_data: ex_store_data,
                     write_reg_addr: ex_write_reg_addr, reg_write: ex_reg_write,
                     mem_read: ex_mem_read, mem_write: ex_mem_write, mem_to_reg: ex_mem_to_reg};

    // Read wins when both read and write are set, so a malformed op is never a store.
    assign m_op            = m.valid & (m.mem_read | m.mem_write);
    assign mem_stall       = m_op & ~dmem.dmem_ready;
    assign dmem.dmem_req   = m_op;
    assign dmem.dmem_we    = m.mem_write & ~m.mem_read;
    assign dmem.dmem_addr  = m.alu_result;
    assign dmem.dmem_wdata = m.store_data;

    assign mem_forward_data   = m.alu_result;
    assign mem_write_reg_addr = m.write_reg_addr;
    assign mem_reg_write      = m.valid & m.reg_write & ~m.mem_read;
    assign wb_forward_data    = wb_write_data;

    assign wb_data_nxt = (m.mem_read && m.mem_to_reg) ? dmem.dmem_rdata : m.alu_result;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         m <= '0;
        else if (!mem_stall) m <= ex_in;
    end

    // A stalled cycle injects a bubble into WB but leaves the data fields alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid          <= 1'b0;
            wb_reg_write      <= 1'b0;
            wb_write_reg_addr <= '0;
            wb_write_data     <= '0;
        end else if (mem_stall) begin
            wb_valid          <= 1'b0;
            wb_reg_write      <= 1'b0;
        end else begin
            wb_valid          <= m.valid;
            wb_reg_write      <= m.valid & m.reg_write;
            wb_write_reg_addr <= m.write_reg_addr;
            wb_write_data     <= wb_data_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (m_op && !dmem.dmem_ready) state_nxt = BUSY;
            BUSY:    if (dmem.dmem_ready)          state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          stall_count <= '0;
        else if (mem_stall && stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
    end

    // BUSY always means the request held in EX/MEM is still outstanding.
    busy_has_op: assert property (@(posedge clk) disable iff (!rst_n) (state == BUSY) |-> m_op);
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a memory responder with programmable wait states,
// a WB scoreboard fed at issue time, and a request-protocol monitor.
module tb_mem_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
    logic [15:0] ex_alu_result, ex_store_data;
    logic [2:0]  ex_write_reg_addr;
    logic        mem_stall, mem_reg_write, wb_valid, wb_reg_write;
    logic [15:0] mem_forward_data, wb_write_data, wb_forward_data, stall_count;
    logic [2:0]  mem_write_reg_addr, wb_write_reg_addr;

    mem_stage_if #(.DATA_W(16)) mif ();

    mem_stage #(.DATA_W(16), .RADDR_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
        .ex_write_reg_addr(ex_write_reg_addr), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
        .mem_stall(mem_stall), .dmem(mif.master),
        .mem_forward_data(mem_forward_data), .mem_write_reg_addr(mem_write_reg_addr),
        .mem_reg_write(mem_reg_write), .wb_valid(wb_valid), .wb_reg_write(wb_reg_write),
        .wb_write_reg_addr(wb_write_reg_addr), .wb_write_data(wb_write_data),
        .wb_forward_data(wb_forward_data), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory responder: ready after wait_cfg request cycles, writes on the ready cycle.
    int          wait_cfg = 0;
    logic [7:0]  wait_cnt;
    logic [15:0] mem [0:255];

    always_comb mif.dmem_ready = mif.dmem_req && (int'(wait_cnt) == wait_cfg);
    always_comb mif.dmem_rdata = mem[mif.dmem_addr[7:0]];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                              wait_cnt <= '0;
        else if (mif.dmem_req && mif.dmem_ready) wait_cnt <= '0;
        else if (mif.dmem_req)                   wait_cnt <= wait_cnt + 8'd1;
    end

    always @(posedge clk)
        if (rst_n && mif.dmem_req && mif.dmem_we && mif.dmem_ready)
            mem[mif.dmem_addr[7:0]] <= mif.dmem_wdata;

    // Scoreboard of expected WB results.
    typedef struct {
        logic        rw;
        logic [2:0]  rd;
        logic [15:0] data;
    } wb_exp_t;
    wb_exp_t sb [$];

    always @(negedge clk) begin
        if (rst_n && wb_valid) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL wb_unexpected: got data %0h expected no writeback", wb_write_data);
            end else begin
                wb_exp_t e;
                e = sb.pop_front();
                check("wb_reg_write", wb_reg_write, e.rw);
                check("wb_write_reg_addr", wb_write_reg_addr, e.rd);
                check("wb_write_data", wb_write_data, e.data);
                check("wb_forward_data", wb_forward_data, e.data);
            end
        end
    end

    // Request monitor: per-window statistics and held-request stability.
    int          cyc = 0, req_cyc = 0, we_cyc = 0, stall_cyc = 0, first_req = -1, last_req = -1;
    logic        prev_req = 1'b0, prev_ready = 1'b0, prev_we = 1'b0;
    logic [15:0] prev_addr = '0, prev_wdata = '0;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            prev_req = 1'b0;
        end else begin
            if (mif.dmem_req) begin
                req_cyc++;
                if (mif.dmem_we) we_cyc++;
                if (first_req < 0) first_req = cyc;
                last_req = cyc;
            end
            if (mem_stall) stall_cyc++;
            if (prev_req && !prev_ready) begin
                check("req_held", mif.dmem_req, 1'b1);
                check("addr_stable", mif.dmem_addr, prev_addr);
                check("wdata_stable", mif.dmem_wdata, prev_wdata);
                check("we_stable", mif.dmem_we, prev_we);
            end
            prev_req   = mif.dmem_req;
            prev_ready = mif.dmem_ready;
            prev_we    = mif.dmem_we;
            prev_addr  = mif.dmem_addr;
            prev_wdata = mif.dmem_wdata;
        end
    end

    task automatic clr_win();
        req_cyc = 0; we_cyc = 0; stall_cyc = 0; first_req = -1; last_req = -1;
    endtask

    // Present one instruction, respect mem_stall, return #1 after its capture edge.
    task automatic issue(input logic v, input logic [15:0] alu, input logic [15:0] sd,
                         input logic [2:0] rd, input logic rw, input logic mr, input logic mw,
                         input logic m2r, input logic [15:0] exp_data);
        int n;
        @(negedge clk);
        ex_valid = v; ex_alu_result = alu; ex_store_data = sd; ex_write_reg_addr = rd;
        ex_reg_write = rw; ex_mem_read = mr; ex_mem_write = mw; ex_mem_to_reg = m2r;
        n = 0;
        while (mem_stall && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++; errors++;
            $display("FAIL issue_timeout: got stall after %0d cycles expected release", n);
        end
        if (v) sb.push_back('{rw: rw, rd: rd, data: exp_data});
        @(posedge clk);
        #1;
        ex_valid = 1'b0; ex_reg_write = 1'b0; ex_mem_read = 1'b0;
        ex_mem_write = 1'b0; ex_mem_to_reg = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (n < 50) begin
            @(negedge clk);
            if (!mif.dmem_req) break;
            n++;
        end
        if (n >= 50) begin
            checks++; errors++;
            $display("FAIL drain_timeout: got req high %0d cycles expected release", n);
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[16] = 16'hBEEF;
        rst_n = 1'b0;
        ex_valid = 0; ex_alu_result = 0; ex_store_data = 0; ex_write_reg_addr = 0;
        ex_reg_write = 0; ex_mem_read = 0; ex_mem_write = 0; ex_mem_to_reg = 0;
        #1;
        check("rst_req", mif.dmem_req, 1'b0);
        check("rst_stall", mem_stall, 1'b0);
        check("rst_wb_reg_write", wb_reg_write, 1'b0);
        check("rst_wb_valid", wb_valid, 1'b0);
        check("rst_stall_count", stall_count, 16'd0);
        #21 rst_n = 1'b1;

        // ALU op
        clr_win();
        issue(1, 16'h1234, 16'h0, 3'd3, 1, 0, 0, 0, 16'h1234);
        check("alu_mem_fwd", mem_forward_data, 16'h1234);
        check("alu_mem_reg_write", mem_reg_write, 1'b1);
        check("alu_mem_rd", mem_write_reg_addr, 3'd3);
        check("alu_req", mif.dmem_req, 1'b0);
        @(posedge clk); #1;
        check("alu_wb_data", wb_write_data, 16'h1234);
        check("alu_wb_rd", wb_write_reg_addr, 3'd3);
        check("alu_wb_rw", wb_reg_write, 1'b1);
        repeat (2) @(negedge clk);
        check("alu_req_cycles", req_cyc, 0);

        // Zero-wait load
        clr_win(); wait_cfg = 0;
        issue(1, 16'h0010, 16'h0, 3'd5, 1, 1, 0, 1, 16'hBEEF);
        check("zl_stall", mem_stall, 1'b0);
        check("zl_req", mif.dmem_req, 1'b1);
        check("zl_mem_reg_write", mem_reg_write, 1'b0);
        repeat (2) @(negedge clk);
        check("zl_stall_cycles", stall_cyc, 0);
        check("zl_req_cycles", req_cyc, 1);
        check("zl_stall_count", stall_count, 16'd0);

        // Store with 3 wait states
        clr_win(); wait_cfg = 3;
        issue(1, 16'h0020, 16'h5A5A, 3'd4, 0, 0, 1, 0, 16'h0020);
        check("st_we", mif.dmem_we, 1'b1);
        check("st_addr", mif.dmem_addr, 16'h0020);
        check("st_wdata", mif.dmem_wdata, 16'h5A5A);
        drain();
        check("st_req_cycles", req_cyc, 4);
        check("st_we_cycles", we_cyc, 4);
        check("st_stall_cycles", stall_cyc, 3);
        check("st_stall_count", stall_count, 16'd3);
        check("st_mem", mem[32], 16'h5A5A);

        // Back-to-back load then store, one wait each
        clr_win(); wait_cfg = 1;
        issue(1, 16'h0020, 16'h0, 3'd2, 1, 1, 0, 1, 16'h5A5A);
        check("b2b_load_mem_reg_write", mem_reg_write, 1'b0);
        check("b2b_load_fwd", mem_forward_data, 16'h0020);
        issue(1, 16'h0030, 16'h0F0F, 3'd6, 0, 0, 1, 0, 16'h0030);
        drain();
        check("b2b_req_cycles", req_cyc, 4);
        check("b2b_req_span", last_req - first_req + 1, 4);
        check("b2b_stall_cycles", stall_cyc, 2);
        check("b2b_stall_count", stall_count, 16'd5);
        check("b2b_mem", mem[48], 16'h0F0F);

        // Bubble carrying load control bits
        clr_win(); wait_cfg = 0;
        issue(0, 16'h0040, 16'h0, 3'd1, 1, 1, 0, 1, 16'h0);
        check("bub_req", mif.dmem_req, 1'b0);
        check("bub_mem_reg_write", mem_reg_write, 1'b0);
        @(posedge clk); #1;
        check("bub_wb_valid", wb_valid, 1'b0);
        check("bub_wb_rw", wb_reg_write, 1'b0);
        repeat (2) @(negedge clk);
        check("bub_req_cycles", req_cyc, 0);

        // Reset in the middle of a stalled load
        wait_cfg = 5;
        issue(1, 16'h0010, 16'h0, 3'd7, 1, 1, 0, 1, 16'hBEEF);
        repeat (2) @(negedge clk);
        check("mid_busy_req", mif.dmem_req, 1'b1);
        check("mid_busy_stall", mem_stall, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_req", mif.dmem_req, 1'b0);
        check("mid_rst_stall", mem_stall, 1'b0);
        check("mid_rst_wb_rw", wb_reg_write, 1'b0);
        check("mid_rst_stall_count", stall_count, 16'd0);
        sb.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        wait_cfg = 0;
        issue(1, 16'h0055, 16'h0, 3'd1, 1, 0, 0, 0, 16'h0055);
        check("post_rst_stall", mem_stall, 1'b0);
        check("post_rst_stall_count", stall_count, 16'd0);
        repeat (3) @(negedge clk);

        check("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
